// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: request handshake, ALU drive/return buses and result
// outputs of the ALU operation sequencer.
//   slave  modport: the sequencer (accepts requests, drives the ALU, owns results)
//   master modport: the control unit / ALU side
//   req_valid/req_ready/req_op/req_a/req_b : request handshake
//   alu_select/alu_a/alu_y/alu_b           : drive to the registered ALU
//   alu_c/alu_carry                        : ALU {Hi,Lo} result and carry
//   res_lo/res_hi/res_carry/done/err/busy  : captured results and status
interface alu_op_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic               req_valid;
  logic               req_ready;
  logic [3:0]         req_op;
  logic [WIDTH-1:0]   req_a;
  logic [WIDTH-1:0]   req_b;
  logic [3:0]         alu_select;
  logic [WIDTH-1:0]   alu_a;
  logic [WIDTH-1:0]   alu_y;
  logic [WIDTH-1:0]   alu_b;
  logic [2*WIDTH-1:0] alu_c;
  logic               alu_carry;
  logic [WIDTH-1:0]   res_lo;
  logic [WIDTH-1:0]   res_hi;
  logic               res_carry;
  logic               done;
  logic               err;
  logic               busy;

  modport master (
    output req_valid, req_op, req_a, req_b, alu_c, alu_carry,
    input  req_ready, alu_select, alu_a, alu_y, alu_b,
           res_lo, res_hi, res_carry, done, err, busy
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, alu_c, alu_carry,
    output req_ready, alu_select, alu_a, alu_y, alu_b,
           res_lo, res_hi, res_carry, done, err, busy
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues one operation at a time to the shared registered
// ALU. A request is taken over a valid/ready handshake, the ALU select is
// driven for exactly one cycle, the sequencer waits out the ALU latency, then
// captures {Hi,Lo}/carry and pulses done. Illegal opcodes pulse err instead.
// Ports:
//   clk   : system clock
//   clear : synchronous active-high reset
//   bus   : alu_op_sequencer_if.slave (handshake, ALU buses, results, status)
// Parameters:
//   ALU_LAT : cycles from the ALU select edge until alu_c is valid (>= 1)
//   WIDTH   : operand width; alu_c is 2*WIDTH
// Build option:
//   DIV_ZERO_CHECK_EN : when defined, div/mod (0101) with req_b == 0 is
//                       rejected without issuing to the ALU.
module alu_op_sequencer #(
  parameter int unsigned ALU_LAT = 1,
  parameter int unsigned WIDTH   = 32
) (
  input logic               clk,
  input logic               clear,
  alu_op_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CAPTURE,
    DONE,
    REJECT
  } state_t;

  localparam int unsigned CW = (ALU_LAT > 2) ? $clog2(ALU_LAT - 1) : 1;

  state_t           state;
  logic [CW-1:0]    wait_cnt;
  logic [3:0]       op_q;
  logic [3:0]       select_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_lo_q;
  logic [WIDTH-1:0] res_hi_q;
  logic             res_carry_q;
  logic             done_q;
  logic             err_q;
  logic             ready_q;
  logic             busy_q;
  logic             reject;

  always_comb begin
    reject = 1'b0;
    case (bus.req_op)
      4'b0000, 4'b0100, 4'b1001, 4'b1011: reject = 1'b1;
      default:                            reject = 1'b0;
    endcase
`ifdef DIV_ZERO_CHECK_EN
    if (bus.req_op == 4'b0101 && bus.req_b == '0) reject = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      op_q        <= '0;
      select_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_lo_q    <= '0;
      res_hi_q    <= '0;
      res_carry_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            if (reject) begin
              state <= REJECT;
              err_q <= 1'b1;
            end else begin
              state    <= ISSUE;
              op_q     <= bus.req_op;
              select_q <= bus.req_op;
              a_q      <= bus.req_a;
              b_q      <= bus.req_b;
            end
          end
        end
        ISSUE: begin
          // Select drops after one cycle so div/mod cannot re-execute.
          select_q <= '0;
          if (ALU_LAT == 1) begin
            state <= CAPTURE;
          end else begin
            state    <= WAIT;
            wait_cnt <= CW'(ALU_LAT - 2);
          end
        end
        WAIT: begin
          if (wait_cnt == '0) state <= CAPTURE;
          else                wait_cnt <= wait_cnt - 1'b1;
        end
        CAPTURE: begin
          res_lo_q <= bus.alu_c[WIDTH-1:0];
          if (op_q == 4'b0011 || op_q == 4'b0101) res_hi_q <= bus.alu_c[2*WIDTH-1:WIDTH];
          if (op_q == 4'b0001 || op_q == 4'b0010) res_carry_q <= bus.alu_carry;
          done_q <= 1'b1;
          state  <= DONE;
        end
        DONE, REJECT: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          a_q     <= '0;
          b_q     <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.alu_select = select_q;
  assign bus.alu_a      = a_q;
  assign bus.alu_y      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.res_lo     = res_lo_q;
  assign bus.res_hi     = res_hi_q;
  assign bus.res_carry  = res_carry_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.busy       = busy_q;
endmodule
